// File: rtl/tpg_pkg.sv
// tpg_pkg: shared types and constants for the test-pattern generator
package tpg_pkg;
  typedef enum logic [1:0] {
    TPG_SOLID   = 2'd0,
    TPG_HRAMP   = 2'd1,
    TPG_BARS    = 2'd2,
    TPG_CHECKER = 2'd3
  } tpg_mode_e;
  typedef enum logic {TPG_IDLE, TPG_ACTIVE} tpg_state_e;
  localparam int TPG_N_BARS = 8;
  localparam int TPG_BAR_W  = $clog2(TPG_N_BARS);
endpackage

// File: rtl/tpg_pattern.sv
// tpg_pattern: combinational pixel generator from beat position, bar index and mode
module tpg_pattern
  import tpg_pkg::*;
#(
  parameter int CH_W    = 4,
  parameter int N_CH    = 3,
  parameter int SQ_LOG2 = 3,
  parameter int PW      = 4
) (
  input  logic [PW-1:0]              h,
  input  logic                       v_sq,
  input  logic [TPG_BAR_W-1:0]       bar,
  input  tpg_mode_e                  mode,
  output logic [N_CH-1:0][CH_W-1:0]  pix
);
  // per-channel pattern select; inverted bar index equals 7-bar for the colour bits
  always_comb begin
    pix = '0;
    for (int c = 0; c < N_CH; c++)
      pix[c] = mode == TPG_SOLID ? {CH_W{1'b1}} :
               mode == TPG_HRAMP ? h[CH_W-1:0] :
               mode == TPG_BARS  ? {CH_W{~bar[c%3]}} :
                                   {CH_W{h[SQ_LOG2] ^ v_sq}};
  end
endmodule

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: AXI4-Stream video test-pattern source; define TPG_MOTION_EN for frame-scrolling patterns
module test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int CH_W    = 4,
  parameter int N_CH    = 3,
  parameter int RES_W   = 16,
  parameter int SQ_LOG2 = 3
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [RES_W-1:0]          H_RES,
  input  logic [RES_W-1:0]          V_RES,
  input  tpg_mode_e                 mode,
  input  logic                      sof,
  output logic                      pix_tvalid,
  input  logic                      pix_tready,
  output logic [N_CH-1:0][CH_W-1:0] pix_tdata,
  output logic                      pix_tlast,
  output logic                      pix_tuser,
  output logic                      busy,
  output logic                      sof_err
);
  localparam int PW = CH_W > SQ_LOG2 ? CH_W : SQ_LOG2 + 1;
  tpg_state_e state, nxt_state;
  logic [RES_W-1:0] h, v, h_max, v_max, bar_w, bar_cnt;
  logic [RES_W-1:0] nxt_h, nxt_v, nxt_h_max, nxt_v_max, nxt_bar_w, nxt_bar_cnt, bw_in;
  logic [TPG_BAR_W-1:0] bar, nxt_bar;
  tpg_mode_e mode_q, nxt_mode;
  logic hs, eol, eob, fin, accept, act;
  logic [PW-1:0] h_pat;
  logic [N_CH-1:0][CH_W-1:0] pix;
`ifdef TPG_MOTION_EN
  logic [7:0] f, nxt_f;
`endif

  assign busy = state == TPG_ACTIVE;

  // next-state and next-beat position; outputs are registered from these next values
  always_comb begin
    hs          = pix_tvalid && pix_tready;
    eol         = h == h_max;
    eob         = bar_cnt == bar_w - RES_W'(1);
    fin         = hs && eol && v == v_max;
    accept      = sof && H_RES != '0 && V_RES != '0 && (state == TPG_IDLE || fin);
    nxt_state   = accept ? TPG_ACTIVE : fin ? TPG_IDLE : state;
    act         = nxt_state == TPG_ACTIVE;
    bw_in       = H_RES >> TPG_BAR_W;
    nxt_h_max   = accept ? H_RES - RES_W'(1) : h_max;
    nxt_v_max   = accept ? V_RES - RES_W'(1) : v_max;
    nxt_mode    = accept ? mode : mode_q;
    nxt_bar_w   = accept ? (bw_in == '0 ? RES_W'(1) : bw_in) : bar_w;
    nxt_h       = accept || (hs && eol) ? '0 : hs ? h + RES_W'(1) : h;
    nxt_v       = accept ? '0 : hs && eol ? v + RES_W'(1) : v;
    nxt_bar_cnt = accept || (hs && (eol || eob)) ? '0 : hs ? bar_cnt + RES_W'(1) : bar_cnt;
    nxt_bar     = accept || (hs && eol) ? '0 :
                  hs && eob && bar != TPG_BAR_W'(TPG_N_BARS - 1) ? bar + TPG_BAR_W'(1) : bar;
`ifdef TPG_MOTION_EN
    nxt_f       = fin ? f + 8'd1 : f;
    h_pat       = PW'(nxt_h + RES_W'(nxt_f));
`else
    h_pat       = PW'(nxt_h);
`endif
  end

  tpg_pattern #(.CH_W(CH_W), .N_CH(N_CH), .SQ_LOG2(SQ_LOG2), .PW(PW)) u_pattern (
    .h    (h_pat),
    .v_sq (nxt_v[SQ_LOG2]),
    .bar  (nxt_bar),
    .mode (nxt_mode),
    .pix  (pix)
  );

  // FSM state register
  always_ff @(posedge aclk)
    state <= !aresetn ? TPG_IDLE : nxt_state;

  // counters, latched frame config and AXIS output register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      h          <= '0;
      v          <= '0;
      h_max      <= '0;
      v_max      <= '0;
      bar_w      <= '0;
      bar_cnt    <= '0;
      bar        <= '0;
      mode_q     <= TPG_SOLID;
      pix_tvalid <= 1'b0;
      pix_tdata  <= '0;
      pix_tlast  <= 1'b0;
      pix_tuser  <= 1'b0;
      sof_err    <= 1'b0;
`ifdef TPG_MOTION_EN
      f          <= '0;
`endif
    end else begin
      h          <= nxt_h;
      v          <= nxt_v;
      h_max      <= nxt_h_max;
      v_max      <= nxt_v_max;
      bar_w      <= nxt_bar_w;
      bar_cnt    <= nxt_bar_cnt;
      bar        <= nxt_bar;
      mode_q     <= nxt_mode;
      pix_tvalid <= act;
      pix_tdata  <= act ? pix : '0;
      pix_tlast  <= act && nxt_h == nxt_h_max;
      pix_tuser  <= act && nxt_h == '0 && nxt_v == '0;
      sof_err    <= sof && !accept;
`ifdef TPG_MOTION_EN
      f          <= nxt_f;
`endif
    end
  end
endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: randomized self-checking bench against a pixel-coordinate reference model
module tb_test_pattern_gen;
  import tpg_pkg::*;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] H_RES = '0, V_RES = '0;
  tpg_mode_e   mode = TPG_SOLID;
  logic        sof = 1'b0;
  logic        pix_tvalid, pix_tready = 1'b0;
  logic [11:0] pix_tdata;
  logic        pix_tlast, pix_tuser, busy, sof_err;
  int          total = 0, passed = 0, fails = 0;
  int          f_model = 0;
  int          nh, nv;
  tpg_mode_e   nm;

  test_pattern_gen dut (
    .aclk(aclk), .aresetn(aresetn), .H_RES(H_RES), .V_RES(V_RES), .mode(mode), .sof(sof),
    .pix_tvalid(pix_tvalid), .pix_tready(pix_tready), .pix_tdata(pix_tdata),
    .pix_tlast(pix_tlast), .pix_tuser(pix_tuser), .busy(busy), .sof_err(sof_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input int h, input int v, input int hr, input tpg_mode_e m, input int f);
    logic [11:0] p;
    int bw, bar, val;
    p = '0;
    bw = hr / 8 < 1 ? 1 : hr / 8;
    bar = h / bw > 7 ? 7 : h / bw;
    for (int c = 0; c < 3; c++) begin
      case (m)
        TPG_SOLID: val = 15;
        TPG_HRAMP: val = (h + f) % 16;
        TPG_BARS:  val = (((7 - bar) >> (c % 3)) & 1) != 0 ? 15 : 0;
        default:   val = ((((h + f) >> 3) ^ (v >> 3)) & 1) != 0 ? 15 : 0;
      endcase
      p[c*4 +: 4] = 4'(val);
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    sof = 1'b0;
    pix_tready = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", pix_tvalid, 0);
    chk("rst_tdata", pix_tdata, 0);
    chk("rst_tlast", pix_tlast, 0);
    chk("rst_tuser", pix_tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sof_err", sof_err, 0);
    aresetn = 1'b1;
    f_model = 0;
  endtask

  // start: issue sof here; stall: percent of not-ready cycles; sof_at: beat with mid-frame sof; chain: back-to-back into nh/nv/nm
  task automatic run_frame(input int hr, input int vr, input tpg_mode_e m, input bit start,
                           input int stall, input int sof_at, input bit chain, input int exp_cycles);
    int n, idx, cyc, budget;
    bit rdy, inj, injected, err_exp;
    n = hr * vr;
    idx = 0;
    cyc = 0;
    budget = 20 * n + 50;
    injected = 0;
    err_exp = 0;
    if (start) begin
      H_RES = 16'(hr);
      V_RES = 16'(vr);
      mode = m;
      sof = 1'b1;
      tick();
      sof = 1'b0;
    end
    while (idx < n && cyc < budget) begin
      H_RES = 16'($urandom);
      V_RES = 16'($urandom);
      mode = tpg_mode_e'($urandom_range(3));
      rdy = stall == 0 ? 1'b1 : $urandom_range(99) >= stall;
      inj = 0;
      if (idx == sof_at && !injected) begin
        rdy = 0;
        inj = 1;
        injected = 1;
        sof = 1'b1;
      end
      if (chain && idx == n - 1 && rdy) begin
        sof = 1'b1;
        H_RES = 16'(nh);
        V_RES = 16'(nv);
        mode = nm;
      end
      pix_tready = rdy;
      chk("tvalid", pix_tvalid, 1);
      chk("busy", busy, 1);
      chk("tdata", pix_tdata, model(idx % hr, idx / hr, hr, m, f_model));
      chk("tlast", pix_tlast, idx % hr == hr - 1);
      chk("tuser", pix_tuser, idx == 0);
      chk("sof_err", sof_err, err_exp);
      tick();
      sof = 1'b0;
      err_exp = inj;
      if (rdy) idx++;
      cyc++;
    end
    pix_tready = 1'b0;
    chk("beats_done", idx, n);
`ifdef TPG_MOTION_EN
    f_model = (f_model + 1) % 256;
`endif
    if (exp_cycles > 0) chk("frame_cycles", cyc, exp_cycles);
    if (!chain) begin
      chk("end_tvalid", pix_tvalid, 0);
      chk("end_busy", busy, 0);
      chk("end_sof_err", sof_err, 0);
    end
  endtask

  initial begin
    do_reset();
    run_frame(4, 2, TPG_HRAMP, 1, 0, -1, 0, 8);
    run_frame(4, 2, TPG_HRAMP, 1, 40, -1, 0, 0);
    run_frame(16, 1, TPG_BARS, 1, 0, -1, 0, 16);
    run_frame(5, 3, TPG_BARS, 1, 30, -1, 0, 0);
    run_frame(37, 2, TPG_BARS, 1, 30, -1, 0, 0);
    run_frame(20, 18, TPG_CHECKER, 1, 25, -1, 0, 0);
    run_frame(3, 2, TPG_SOLID, 1, 50, -1, 0, 0);
    run_frame(6, 3, TPG_HRAMP, 1, 20, 7, 0, 0);
    H_RES = 16'd0;
    V_RES = 16'd4;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    chk("zero_h_sof_err", sof_err, 1);
    chk("zero_h_tvalid", pix_tvalid, 0);
    chk("zero_h_busy", busy, 0);
    tick();
    chk("zero_h_err_pulse", sof_err, 0);
    nh = 9;
    nv = 2;
    nm = TPG_CHECKER;
    run_frame(4, 2, TPG_HRAMP, 1, 30, -1, 1, 0);
    run_frame(9, 2, TPG_CHECKER, 0, 30, -1, 0, 0);
    run_frame(4, 2, TPG_HRAMP, 1, 0, -1, 0, 8);
    H_RES = 16'd8;
    V_RES = 16'd4;
    mode = TPG_HRAMP;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    pix_tready = 1'b1;
    tick();
    tick();
    pix_tready = 1'b0;
    aresetn = 1'b0;
    tick();
    chk("midrst_tvalid", pix_tvalid, 0);
    chk("midrst_tdata", pix_tdata, 0);
    chk("midrst_tlast", pix_tlast, 0);
    chk("midrst_tuser", pix_tuser, 0);
    chk("midrst_busy", busy, 0);
    aresetn = 1'b1;
    f_model = 0;
    tick();
    chk("post_rst_idle", pix_tvalid, 0);
    run_frame(12, 2, TPG_HRAMP, 1, 30, -1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
